vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz raster timing for the display path from the 25 MHz pixel clock.
- Drives the pixel coordinates (hc, vc) and visible-area flag (valid) consumed by the colour-selection stage.
- Drives the hsync/vsync pins, delayed to line up with that stage's ROM-read plus output-register latency.
- Provides frame_tick, frame_cnt and line_tick so game logic can update object positions once per frame during vertical blanking.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SW, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SW, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 2, pipeline delay (cycles, 0..4) applied to hsync/vsync only
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)

Ports:
- clk_25m, in, 1, pixel clock
- rst, in, 1, asynchronous active-low reset
- hc, out, 10, horizontal pixel counter, 0..H_TOT-1
- vc, out, 10, vertical line counter, 0..V_TOT-1
- valid, out, 1, high when hc<H_VIS and vc<V_VIS
- hsync, out, 1, horizontal sync to connector, delayed SYNC_DELAY cycles
- vsync, out, 1, vertical sync to connector, delayed SYNC_DELAY cycles
- line_tick, out, 1, one-cycle pulse when hc==0
- frame_tick, out, 1, one-cycle pulse when hc==0 and vc==V_VIS (start of vblank)
- frame_cnt, out, 16, frames completed since reset, wraps

Behaviour:
- Derived totals: H_TOT = H_VIS+H_FP+H_SW+H_BP = 800; V_TOT = V_VIS+V_FP+V_SW+V_BP = 525.
- Elaboration fails if H_TOT > 1024, V_TOT > 1024, or SYNC_DELAY > 4.
- Reset (rst low, asynchronous):
  - hc = H_TOT-1, vc = V_TOT-1 (pre-roll position).
  - valid, line_tick, frame_tick = 0; frame_cnt = 0.
  - hsync = inactive level (!H_POL); vsync = inactive level (!V_POL).
  - Every stage of both sync delay pipes = inactive level.
- First rising edge after rst goes high: wrap from pre-roll gives hc=0, vc=0, valid=1, line_tick=1.
- Counters advance every cycle:
  - hc: hc+1, or 0 when hc==H_TOT-1.
  - vc: increments only on the cycle hc wraps; 0 when vc==V_TOT-1 and hc wraps.
- hc, vc, valid, line_tick, frame_tick are all registered:
  - Each is computed from next-state counter values, so all are mutually consistent in the same cycle.
  - No combinational path to any output.
- Raw sync (internal):
  - Horizontal active when H_VIS+H_FP <= hc < H_VIS+H_FP+H_SW, i.e. 656..751.
  - Vertical active when V_VIS+V_FP <= vc < V_VIS+V_FP+V_SW, i.e. 490..491.
  - Both evaluated on the registered hc/vc.
- Sync delay:
  - Each raw sync passes through a SYNC_DELAY-stage register pipe, then is driven at its active level per H_POL/V_POL.
  - SYNC_DELAY=0: the polarity-adjusted raw sync is itself registered (one flop), so it still has no combinational path to the pin.
- Vsync changes only on cycles where hc is SYNC_DELAY past a line wrap.
- frame_cnt increments by 1, 16-bit wrap 65535->0, in the same edge that raises frame_tick.
- Reset mid-frame returns all state immediately to the reset values; no partial frame completes and frame_cnt does not increment.

Test Plan:
- Reset: hold rst low 5 cycles -> hc=799, vc=524, valid=0, hsync=vsync=1, frame_cnt=0; first edge after release -> hc=0, vc=0, valid=1, line_tick=1.
- Line wrap: run to hc=639 (valid=1), next hc=640 (valid=0); hc=799 -> next hc=0, vc+1, line_tick=1 for exactly one cycle.
- Hsync, SYNC_DELAY=2: hsync falls on the cycle hc==658 and rises on the cycle hc==754; measured low width is exactly 96 cycles, every line.
- Vsync/frame: at hc=0, vc=480 -> frame_tick=1, frame_cnt 0->1; vsync low for exactly 1600 cycles; at vc=524, hc=799 -> next vc=0, hc=0.
- Frame count wrap: force frame_cnt=65535, run to vc=480 -> frame_cnt=0, frame_tick=1.
- Mid-frame reset: assert rst at hc=300, vc=200 -> all outputs take reset values the same instant; after release, frame timing restarts at hc=0, vc=0 with frame_cnt=0.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the VGA timing generator to the colour-selection
// stage, the sync pins and the game logic. The generator drives every signal
// (master); consumers only observe (slave). There is no valid/ready handshake:
// every signal is a free-running registered output, updated once per pixel
// clock, and consumers sample it on the same clock.
interface vga_timing_if;
   logic [9:0]  hc;
   logic [9:0]  vc;
   logic        valid;
   logic        hsync;
   logic        vsync;
   logic        line_tick;
   logic        frame_tick;
   logic [15:0] frame_cnt;

   modport master (
      output hc, vc, valid, hsync, vsync, line_tick, frame_tick, frame_cnt
   );

   modport slave (
      input  hc, vc, valid, hsync, vsync, line_tick, frame_tick, frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster timing generator running on the 25 MHz pixel clock.
// Pixel/line counters and the per-pixel flags are registered from next-state
// counter values, so hc, vc, valid and the ticks always agree in a cycle.
// Sync pulses are decoded from the registered counters and delayed by
// SYNC_DELAY cycles to match the colour stage's ROM read + output register.
module vga_timing_gen #(
   parameter int H_VIS      = 640,
   parameter int H_FP       = 16,
   parameter int H_SW       = 96,
   parameter int H_BP       = 48,
   parameter int V_VIS      = 480,
   parameter int V_FP       = 10,
   parameter int V_SW       = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_DELAY = 2,
   parameter bit H_POL      = 1'b0,
   parameter bit V_POL      = 1'b0
) (
   input  logic               clk_25m,
   input  logic               rst,
   vga_timing_if.master       o_vga
);

   localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

   // SYNC_DELAY of 0 still keeps one flop so the pins never see a comb path.
   localparam int STAGES = (SYNC_DELAY == 0) ? 1 : SYNC_DELAY;

   // Compare constants carry one spare bit so a 1024 total cannot overflow.
   localparam logic [9:0]  HC_LAST  = 10'(H_TOT - 1);
   localparam logic [9:0]  VC_LAST  = 10'(V_TOT - 1);
   localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
   localparam logic [10:0] V_VIS_C  = 11'(V_VIS);
   localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SW);
   localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SW);

   if (H_TOT > 1024) begin : g_bad_h_tot
      $error("vga_timing_gen: H_TOT must not exceed 1024");
   end
   if (V_TOT > 1024) begin : g_bad_v_tot
      $error("vga_timing_gen: V_TOT must not exceed 1024");
   end
   if (SYNC_DELAY > 4 || SYNC_DELAY < 0) begin : g_bad_sync_delay
      $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
   end

   logic [9:0]        r_hc;
   logic [9:0]        r_vc;
   logic              r_valid;
   logic              r_line_tick;
   logic              r_frame_tick;
   logic [15:0]       r_frame_cnt;
   logic [STAGES-1:0] r_hs_pipe;
   logic [STAGES-1:0] r_vs_pipe;

   logic       w_hc_wrap;
   logic [9:0] w_hc_nxt;
   logic [9:0] w_vc_nxt;
   logic       w_frame_start;
   logic       w_hs_lvl;
   logic       w_vs_lvl;

   // Next-state counters; vc only moves on the cycle hc wraps.
   assign w_hc_wrap     = (r_hc == HC_LAST);
   assign w_hc_nxt      = w_hc_wrap ? 10'd0 : r_hc + 10'd1;
   assign w_vc_nxt      = !w_hc_wrap       ? r_vc  :
                          (r_vc == VC_LAST) ? 10'd0 : r_vc + 10'd1;
   assign w_frame_start = (w_hc_nxt == 10'd0) && ({1'b0, w_vc_nxt} == V_VIS_C);

   // Raw syncs decoded from the registered counters, already at pin polarity.
   assign w_hs_lvl = (({1'b0, r_hc} >= HS_START) && ({1'b0, r_hc} < HS_END)) ? H_POL : ~H_POL;
   assign w_vs_lvl = (({1'b0, r_vc} >= VS_START) && ({1'b0, r_vc} < VS_END)) ? V_POL : ~V_POL;

   // Counters, visible flag, ticks and frame counter, all from next-state values.
   always_ff @(posedge clk_25m or negedge rst) begin
      if (!rst) begin
         r_hc         <= HC_LAST;
         r_vc         <= VC_LAST;
         r_valid      <= 1'b0;
         r_line_tick  <= 1'b0;
         r_frame_tick <= 1'b0;
         r_frame_cnt  <= 16'd0;
      end else begin
         r_hc         <= w_hc_nxt;
         r_vc         <= w_vc_nxt;
         r_valid      <= ({1'b0, w_hc_nxt} < H_VIS_C) && ({1'b0, w_vc_nxt} < V_VIS_C);
         r_line_tick  <= (w_hc_nxt == 10'd0);
         r_frame_tick <= w_frame_start;
         r_frame_cnt  <= w_frame_start ? r_frame_cnt + 16'd1 : r_frame_cnt;
      end
   end

   // Sync delay pipes; every stage holds the inactive level out of reset.
   always_ff @(posedge clk_25m or negedge rst) begin
      if (!rst) begin
         r_hs_pipe <= {STAGES{~H_POL}};
         r_vs_pipe <= {STAGES{~V_POL}};
      end else begin
         r_hs_pipe[0] <= w_hs_lvl;
         r_vs_pipe[0] <= w_vs_lvl;
         for (int i = 1; i < STAGES; i++) begin
            r_hs_pipe[i] <= r_hs_pipe[i-1];
            r_vs_pipe[i] <= r_vs_pipe[i-1];
         end
      end
   end

   assign o_vga.hc         = r_hc;
   assign o_vga.vc         = r_vc;
   assign o_vga.valid      = r_valid;
   assign o_vga.line_tick  = r_line_tick;
   assign o_vga.frame_tick = r_frame_tick;
   assign o_vga.frame_cnt  = r_frame_cnt;
   assign o_vga.hsync      = r_hs_pipe[STAGES-1];
   assign o_vga.vsync      = r_vs_pipe[STAGES-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing is the real 640-pixel
// line (800 clocks); the vertical geometry is shortened to V_VIS=8, V_FP=2,
// V_SW=2, V_BP=3 (V_TOT=15) so whole frames fit in a short run. Vsync still
// spans two full lines (1600 clocks) and frame_tick lands at vc==V_VIS.
// Outputs are sampled on the falling clock edge.
module tb_vga_timing_gen;

   localparam int V_VIS_T = 8;
   localparam int V_LAST  = 14;

   logic clk;
   logic rst;

   int n_checks = 0;
   int n_errors = 0;

   vga_timing_if vga_bus ();

   vga_timing_gen #(
      .H_VIS(640), .H_FP(16), .H_SW(96), .H_BP(48),
      .V_VIS(V_VIS_T), .V_FP(2), .V_SW(2), .V_BP(3),
      .SYNC_DELAY(2), .H_POL(1'b0), .V_POL(1'b0)
   ) dut (
      .clk_25m (clk),
      .rst     (rst),
      .o_vga   (vga_bus.master)
   );

   // 25 MHz pixel clock.
   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic prev;
      int   fall_hc, rise_hc, low_cnt;
      int   fall_vc, rise_vc;
      bit   done;

      // Reset held for 5 cycles: pre-roll position, everything idle.
      rst = 1'b0;
      step(5);
      check("rst_hc", 32'(vga_bus.hc), 799);
      check("rst_vc", 32'(vga_bus.vc), V_LAST);
      check("rst_valid", 32'(vga_bus.valid), 0);
      check("rst_hsync", 32'(vga_bus.hsync), 1);
      check("rst_vsync", 32'(vga_bus.vsync), 1);
      check("rst_line_tick", 32'(vga_bus.line_tick), 0);
      check("rst_frame_tick", 32'(vga_bus.frame_tick), 0);
      check("rst_frame_cnt", 32'(vga_bus.frame_cnt), 0);

      // First edge after release wraps out of pre-roll.
      rst = 1'b1;
      step(1);
      check("first_hc", 32'(vga_bus.hc), 0);
      check("first_vc", 32'(vga_bus.vc), 0);
      check("first_valid", 32'(vga_bus.valid), 1);
      check("first_line_tick", 32'(vga_bus.line_tick), 1);
      check("first_frame_tick", 32'(vga_bus.frame_tick), 0);
      step(1);
      check("hc1_line_tick", 32'(vga_bus.line_tick), 0);
      check("hc1_hc", 32'(vga_bus.hc), 1);

      // Visible/blank boundary at hc 639 -> 640.
      step(638);
      check("hc639_hc", 32'(vga_bus.hc), 639);
      check("hc639_valid", 32'(vga_bus.valid), 1);
      step(1);
      check("hc640_hc", 32'(vga_bus.hc), 640);
      check("hc640_valid", 32'(vga_bus.valid), 0);
      check("hc640_hsync", 32'(vga_bus.hsync), 1);

      // Hsync position and width over three consecutive lines.
      for (int ln = 0; ln < 3; ln++) begin
         fall_hc = -1;
         rise_hc = -1;
         low_cnt = 0;
         for (int k = 0; k < 800; k++) begin
            prev = vga_bus.hsync;
            @(negedge clk);
            if (prev && !vga_bus.hsync) fall_hc = int'(vga_bus.hc);
            if (!prev && vga_bus.hsync) rise_hc = int'(vga_bus.hc);
            if (!vga_bus.hsync) low_cnt++;
         end
         check("hsync_fall_hc", 32'(fall_hc), 658);
         check("hsync_rise_hc", 32'(rise_hc), 754);
         check("hsync_low_width", 32'(low_cnt), 96);
      end

      // Line wrap: now at hc=640 of vc=3.
      step(159);
      check("wrap_pre_hc", 32'(vga_bus.hc), 799);
      check("wrap_pre_vc", 32'(vga_bus.vc), 3);
      check("wrap_pre_line_tick", 32'(vga_bus.line_tick), 0);
      step(1);
      check("wrap_hc", 32'(vga_bus.hc), 0);
      check("wrap_vc", 32'(vga_bus.vc), 4);
      check("wrap_line_tick", 32'(vga_bus.line_tick), 1);
      step(1);
      check("wrap_line_tick_drop", 32'(vga_bus.line_tick), 0);

      // Start of vertical blanking: frame_tick and frame_cnt 0 -> 1.
      step(3198);
      check("vb_pre_hc", 32'(vga_bus.hc), 799);
      check("vb_pre_vc", 32'(vga_bus.vc), V_VIS_T - 1);
      check("vb_pre_frame_tick", 32'(vga_bus.frame_tick), 0);
      check("vb_pre_frame_cnt", 32'(vga_bus.frame_cnt), 0);
      step(1);
      check("vb_vc", 32'(vga_bus.vc), V_VIS_T);
      check("vb_frame_tick", 32'(vga_bus.frame_tick), 1);
      check("vb_frame_cnt", 32'(vga_bus.frame_cnt), 1);
      check("vb_valid", 32'(vga_bus.valid), 0);
      step(1);
      check("vb_frame_tick_drop", 32'(vga_bus.frame_tick), 0);
      check("vb_frame_cnt_hold", 32'(vga_bus.frame_cnt), 1);

      // Vsync position and width, running up to the last pixel of the frame.
      fall_hc = -1; fall_vc = -1;
      rise_hc = -1; rise_vc = -1;
      low_cnt = 0;
      done    = 1'b0;
      for (int k = 0; k < 6000 && !done; k++) begin
         prev = vga_bus.vsync;
         @(negedge clk);
         if (prev && !vga_bus.vsync) begin
            fall_hc = int'(vga_bus.hc);
            fall_vc = int'(vga_bus.vc);
         end
         if (!prev && vga_bus.vsync) begin
            rise_hc = int'(vga_bus.hc);
            rise_vc = int'(vga_bus.vc);
         end
         if (!vga_bus.vsync) low_cnt++;
         if (vga_bus.hc == 10'd799 && vga_bus.vc == 10'(V_LAST)) done = 1'b1;
      end
      check("frame_end_reached", 32'(done), 1);
      check("vsync_fall_hc", 32'(fall_hc), 2);
      check("vsync_fall_vc", 32'(fall_vc), 10);
      check("vsync_rise_hc", 32'(rise_hc), 2);
      check("vsync_rise_vc", 32'(rise_vc), 12);
      check("vsync_low_width", 32'(low_cnt), 1600);
      step(1);
      check("fwrap_hc", 32'(vga_bus.hc), 0);
      check("fwrap_vc", 32'(vga_bus.vc), 0);
      check("fwrap_valid", 32'(vga_bus.valid), 1);
      check("fwrap_line_tick", 32'(vga_bus.line_tick), 1);
      check("fwrap_frame_cnt", 32'(vga_bus.frame_cnt), 1);

      // Mid-frame reset at hc=300, vc=3: reset values appear at once.
      step(2700);
      check("mid_pre_hc", 32'(vga_bus.hc), 300);
      check("mid_pre_vc", 32'(vga_bus.vc), 3);
      rst = 1'b0;
      #1;
      check("mid_rst_hc", 32'(vga_bus.hc), 799);
      check("mid_rst_vc", 32'(vga_bus.vc), V_LAST);
      check("mid_rst_valid", 32'(vga_bus.valid), 0);
      check("mid_rst_frame_cnt", 32'(vga_bus.frame_cnt), 0);
      check("mid_rst_hsync", 32'(vga_bus.hsync), 1);
      check("mid_rst_vsync", 32'(vga_bus.vsync), 1);
      step(2);
      rst = 1'b1;
      step(1);
      check("restart_hc", 32'(vga_bus.hc), 0);
      check("restart_vc", 32'(vga_bus.vc), 0);
      check("restart_line_tick", 32'(vga_bus.line_tick), 1);
      check("restart_frame_cnt", 32'(vga_bus.frame_cnt), 0);

      // Frame counter wrap: preload 65535, then run to the next vblank start.
      force dut.r_frame_cnt = 16'hFFFF;
      step(1);
      release dut.r_frame_cnt;
      check("preload_frame_cnt", 32'(vga_bus.frame_cnt), 65535);
      step(6398);
      check("cwrap_pre_hc", 32'(vga_bus.hc), 799);
      check("cwrap_pre_vc", 32'(vga_bus.vc), V_VIS_T - 1);
      check("cwrap_pre_frame_cnt", 32'(vga_bus.frame_cnt), 65535);
      step(1);
      check("cwrap_frame_tick", 32'(vga_bus.frame_tick), 1);
      check("cwrap_frame_cnt", 32'(vga_bus.frame_cnt), 0);
      check("cwrap_vc", 32'(vga_bus.vc), V_VIS_T);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
